// File: rtl/exe_stage.sv
// Execute stage of the five-stage ARM pipeline: operand forwarding, Val2 generation,
// ALU with NZCV flags, branch target, and the EXE/MEM and status registers.
module exe_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic [3:0]       exe_cmd,
  input  logic             wb_en,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             s_bit,
  input  logic             imm,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] val_rn,
  input  logic [WIDTH-1:0] val_rm,
  input  logic [11:0]      shift_operand,
  input  logic [23:0]      signed_imm_24,
  input  logic [3:0]       dest,
  input  logic [1:0]       sel_src1,
  input  logic [1:0]       sel_src2,
  input  logic [WIDTH-1:0] mem_alu_res,
  input  logic [WIDTH-1:0] wb_value,
  output logic [WIDTH-1:0] br_addr,
  output logic [3:0]       status,
  output logic             exe_wb_en,
  output logic             exe_mem_r_en,
  output logic             exe_mem_w_en,
  output logic [WIDTH-1:0] exe_alu_res,
  output logic [WIDTH-1:0] exe_st_val,
  output logic [3:0]       exe_dest
);

  localparam logic [3:0] CmdMov = 4'b0001;
  localparam logic [3:0] CmdMvn = 4'b1001;
  localparam logic [3:0] CmdAdd = 4'b0010;
  localparam logic [3:0] CmdAdc = 4'b0011;
  localparam logic [3:0] CmdSub = 4'b0100;
  localparam logic [3:0] CmdSbc = 4'b0101;
  localparam logic [3:0] CmdAnd = 4'b0110;
  localparam logic [3:0] CmdOrr = 4'b0111;
  localparam logic [3:0] CmdEor = 4'b1000;

  logic [WIDTH-1:0] op1, op2_raw, val2, imm_rot, alu_res;
  logic [WIDTH:0]   sum;
  logic [4:0]       rot_amt, sh_amt;
  logic             alu_c, alu_v, cmd_valid;

  logic [3:0]       status_q, dest_q;
  logic [WIDTH-1:0] alu_res_q, st_val_q;
  logic             wb_en_q, mem_r_en_q, mem_w_en_q;

  // Select 2'b11 falls through to the register value.
  always_comb begin
    op1 = val_rn;
    case (sel_src1)
      2'b01:   op1 = mem_alu_res;
      2'b10:   op1 = wb_value;
      default: op1 = val_rn;
    endcase
    op2_raw = val_rm;
    case (sel_src2)
      2'b01:   op2_raw = mem_alu_res;
      2'b10:   op2_raw = wb_value;
      default: op2_raw = val_rm;
    endcase
  end

  // Shifts by WIDTH yield zero, so the rotate halves collapse cleanly for amount 0.
  always_comb begin
    imm_rot = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
    rot_amt = {shift_operand[11:8], 1'b0};
    sh_amt  = shift_operand[11:7];
    val2    = op2_raw;
    if (imm) begin
      val2 = (imm_rot >> rot_amt) | (imm_rot << (WIDTH - rot_amt));
    end else if (mem_r_en || mem_w_en) begin
      val2 = {{(WIDTH-12){1'b0}}, shift_operand};
    end else begin
      case (shift_operand[6:5])
        2'b00:   val2 = op2_raw << sh_amt;
        2'b01:   val2 = op2_raw >> sh_amt;
        2'b10:   val2 = $unsigned($signed(op2_raw) >>> sh_amt);
        default: val2 = (op2_raw >> sh_amt) | (op2_raw << (WIDTH - sh_amt));
      endcase
    end
  end

  always_comb begin
    alu_res   = '0;
    sum       = '0;
    alu_c     = status_q[1];
    alu_v     = status_q[0];
    cmd_valid = 1'b1;
    case (exe_cmd)
      CmdMov: alu_res = val2;
      CmdMvn: alu_res = ~val2;
      CmdAdd, CmdAdc: begin
        sum     = {1'b0, op1} + {1'b0, val2}
                + {{WIDTH{1'b0}}, (exe_cmd == CmdAdc) && status_q[1]};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op1[WIDTH-1] == val2[WIDTH-1]) && (alu_res[WIDTH-1] != op1[WIDTH-1]);
      end
      CmdSub, CmdSbc: begin
        // op1 + ~val2 + carry: the carry out is the inverted borrow.
        sum     = {1'b0, op1} + {1'b0, ~val2}
                + {{WIDTH{1'b0}}, (exe_cmd == CmdSub) || status_q[1]};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op1[WIDTH-1] != val2[WIDTH-1]) && (alu_res[WIDTH-1] != op1[WIDTH-1]);
      end
      CmdAnd:  alu_res = op1 & val2;
      CmdOrr:  alu_res = op1 | val2;
      CmdEor:  alu_res = op1 ^ val2;
      default: cmd_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= '0;
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
    end else if (!freeze) begin
      alu_res_q  <= alu_res;
      st_val_q   <= op2_raw;
      dest_q     <= dest;
      wb_en_q    <= wb_en;
      mem_r_en_q <= mem_r_en;
      mem_w_en_q <= mem_w_en;
      if (s_bit && cmd_valid) begin
        status_q <= {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
      end
    end
  end

  assign br_addr      = pc + {{(WIDTH-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};
  assign status       = status_q;
  assign exe_alu_res  = alu_res_q;
  assign exe_st_val   = st_val_q;
  assign exe_dest     = dest_q;
  assign exe_wb_en    = wb_en_q;
  assign exe_mem_r_en = mem_r_en_q;
  assign exe_mem_w_en = mem_w_en_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus randomized traffic
// checked against an arithmetic reference model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic [3:0]  exe_cmd;
  logic        wb_en, mem_r_en, mem_w_en, s_bit, imm;
  logic [31:0] pc, val_rn, val_rm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_alu_res, wb_value;
  logic [31:0] br_addr, exe_alu_res, exe_st_val;
  logic [3:0]  status, exe_dest;
  logic        exe_wb_en, exe_mem_r_en, exe_mem_w_en;

  int total = 0;
  int bad   = 0;

  // Reference model state: expected registered outputs.
  logic [31:0] m_res, m_st;
  logic [3:0]  m_dest, m_status;
  logic        m_wb, m_mr, m_mw;

  always #5 clk = ~clk;

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .exe_cmd(exe_cmd), .wb_en(wb_en),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .s_bit(s_bit), .imm(imm), .pc(pc),
    .val_rn(val_rn), .val_rm(val_rm), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .dest(dest), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_alu_res(mem_alu_res), .wb_value(wb_value), .br_addr(br_addr), .status(status),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
    .exe_alu_res(exe_alu_res), .exe_st_val(exe_st_val), .exe_dest(exe_dest)
  );

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] reg_v);
    if (sel == 2'b01) return mem_alu_res;
    if (sel == 2'b10) return wb_value;
    return reg_v;
  endfunction

  function automatic logic [31:0] model_val2(input logic [31:0] raw);
    int unsigned     n;
    longint unsigned x;
    int              s;
    if (imm) begin
      n = 2 * int'(shift_operand[11:8]);
      x = 64'(shift_operand[7:0]);
      return 32'((x >> n) | (x << (32 - n)));
    end
    if (mem_r_en || mem_w_en) return {20'd0, shift_operand};
    n = int'(shift_operand[11:7]);
    x = 64'(raw);
    case (shift_operand[6:5])
      2'd0: return 32'(x << n);
      2'd1: return 32'(x >> n);
      2'd2: begin
        s = raw;
        return 32'(s >>> n);
      end
      default: return 32'((x >> n) | (x << (32 - n)));
    endcase
  endfunction

  // Flags from exact wide arithmetic: C from the true unsigned result, V when the
  // true signed result does not fit in 32 bits.
  task automatic model_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic c, output logic v,
                           output logic ok);
    longint unsigned ua, ub, ur, k;
    longint          sa, sb, sr;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    c  = m_status[1];
    v  = m_status[0];
    ok = 1'b1;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd2, 4'd3: begin
        k  = (cmd == 4'd3 && m_status[1]) ? 64'd1 : 64'd0;
        ur = ua + ub + k;
        sr = sa + sb + longint'(k);
        r  = ur[31:0];
        c  = ur[32];
        v  = (sr != longint'($signed(r)));
      end
      4'd4, 4'd5: begin
        k  = (cmd == 4'd5 && !m_status[1]) ? 64'd1 : 64'd0;
        ur = ua - ub - k;
        sr = sa - sb - longint'(k);
        r  = ur[31:0];
        c  = (ua >= ub + k);
        v  = (sr != longint'($signed(r)));
      end
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      default: ok = 1'b0;
    endcase
  endtask

  // Update the model from the current inputs, then advance one clock.
  task automatic step();
    logic [31:0] o1, o2, v2, r;
    logic        c, v, ok;
    if (rst) begin
      m_res = '0; m_st = '0; m_dest = '0; m_status = '0;
      m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
    end else if (!freeze) begin
      o1 = fwd(sel_src1, val_rn);
      o2 = fwd(sel_src2, val_rm);
      v2 = model_val2(o2);
      model_alu(exe_cmd, o1, v2, r, c, v, ok);
      m_res = r; m_st = o2; m_dest = dest;
      m_wb = wb_en; m_mr = mem_r_en; m_mw = mem_w_en;
      if (s_bit && ok) m_status = {r[31], r == 32'd0, c, v};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    rst = 1'b0; freeze = 1'b0; exe_cmd = 4'd0; wb_en = 1'b0; mem_r_en = 1'b0;
    mem_w_en = 1'b0; s_bit = 1'b0; imm = 1'b0; pc = '0; val_rn = '0; val_rm = '0;
    shift_operand = '0; signed_imm_24 = '0; dest = '0; sel_src1 = '0; sel_src2 = '0;
    mem_alu_res = '0; wb_value = '0;
  endtask

  task automatic set_imm_op(input logic [3:0] cmd, input logic s, input logic [31:0] rn,
                            input logic [11:0] so);
    set_nop();
    exe_cmd = cmd; s_bit = s; val_rn = rn; imm = 1'b1; shift_operand = so; wb_en = 1'b1;
  endtask

  task automatic test_reset();
    set_nop();
    rst = 1'b1; exe_cmd = 4'd2; wb_en = 1'b1; mem_r_en = 1'b1; mem_w_en = 1'b1;
    s_bit = 1'b1; val_rn = 32'h1234; val_rm = 32'h5678; dest = 4'd9;
    step();
    step();
    total++;
    if ({status, exe_dest, exe_wb_en, exe_mem_r_en, exe_mem_w_en} !== 11'd0) begin
      bad++;
      $display("FAIL reset_ctrl: got %h want 0",
               {status, exe_dest, exe_wb_en, exe_mem_r_en, exe_mem_w_en});
    end
    total++;
    if (exe_alu_res !== 32'd0 || exe_st_val !== 32'd0) begin
      bad++;
      $display("FAIL reset_data: got res=%h st=%h want 0", exe_alu_res, exe_st_val);
    end
  endtask

  task automatic test_add_imm();
    set_imm_op(4'b0010, 1'b0, 32'd5, 12'h003);
    step();
    total++;
    if (exe_alu_res !== 32'd8) begin
      bad++; $display("FAIL add_imm: got %h want 8", exe_alu_res);
    end
    total++;
    if (status !== 4'b0000) begin
      bad++; $display("FAIL add_imm_status: got %b want 0000", status);
    end
  endtask

  task automatic test_sub_adc();
    set_imm_op(4'b0100, 1'b1, 32'd3, 12'h005);
    step();
    total++;
    if (exe_alu_res !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL sub_res: got %h want fffffffe", exe_alu_res);
    end
    total++;
    if (status !== 4'b1000) begin
      bad++; $display("FAIL sub_flags: got %b want 1000", status);
    end
    set_imm_op(4'b0011, 1'b0, 32'd0, 12'h000);
    step();
    total++;
    if (exe_alu_res !== 32'd0) begin
      bad++; $display("FAIL adc_c0: got %h want 0", exe_alu_res);
    end
  endtask

  task automatic test_overflow_mov();
    set_imm_op(4'b0010, 1'b1, 32'h7FFF_FFFF, 12'h001);
    step();
    total++;
    if (exe_alu_res !== 32'h8000_0000 || status !== 4'b1001) begin
      bad++;
      $display("FAIL add_ovf: got res=%h nzcv=%b want 80000000/1001", exe_alu_res, status);
    end
    set_imm_op(4'b0001, 1'b1, 32'hDEAD_BEEF, 12'h000);
    step();
    total++;
    if (exe_alu_res !== 32'd0 || status !== 4'b0101) begin
      bad++;
      $display("FAIL mov_keep_cv: got res=%h nzcv=%b want 0/0101", exe_alu_res, status);
    end
  endtask

  task automatic test_back_to_back();
    set_imm_op(4'b0100, 1'b1, 32'd5, 12'h003);
    step();
    total++;
    if (status !== 4'b0010) begin
      bad++; $display("FAIL cmp_carry: got %b want 0010", status);
    end
    set_imm_op(4'b0011, 1'b1, 32'd0, 12'h000);
    step();
    total++;
    if (exe_alu_res !== 32'd1 || status !== 4'b0000) begin
      bad++;
      $display("FAIL adc_c1: got res=%h nzcv=%b want 1/0000", exe_alu_res, status);
    end
    set_imm_op(4'b0101, 1'b0, 32'd5, 12'h003);
    step();
    total++;
    if (exe_alu_res !== 32'd1) begin
      bad++; $display("FAIL sbc_c0: got %h want 1", exe_alu_res);
    end
  endtask

  task automatic test_forwarding();
    set_nop();
    exe_cmd = 4'b0010; wb_en = 1'b1; dest = 4'd3;
    val_rn = 32'hAAAA_0000; val_rm = 32'h5555_0000;
    sel_src1 = 2'b01; mem_alu_res = 32'h10;
    sel_src2 = 2'b10; wb_value = 32'h20;
    shift_operand = 12'h200;
    step();
    total++;
    if (exe_alu_res !== 32'h210 || exe_dest !== 4'd3 || exe_wb_en !== 1'b1) begin
      bad++;
      $display("FAIL fwd_add: got res=%h dest=%0d wb=%b want 210/3/1",
               exe_alu_res, exe_dest, exe_wb_en);
    end
    wb_en = 1'b0; mem_w_en = 1'b1; shift_operand = 12'h004;
    step();
    total++;
    if (exe_alu_res !== 32'h14 || exe_st_val !== 32'h20 || exe_mem_w_en !== 1'b1) begin
      bad++;
      $display("FAIL fwd_str: got addr=%h st=%h w=%b want 14/20/1",
               exe_alu_res, exe_st_val, exe_mem_w_en);
    end
    sel_src1 = 2'b11; sel_src2 = 2'b11; mem_w_en = 1'b0; mem_r_en = 1'b1;
    val_rn = 32'h100; val_rm = 32'h77; shift_operand = 12'h008;
    step();
    total++;
    if (exe_alu_res !== 32'h108 || exe_st_val !== 32'h77 || exe_mem_r_en !== 1'b1) begin
      bad++;
      $display("FAIL sel11_ldr: got addr=%h st=%h r=%b want 108/77/1",
               exe_alu_res, exe_st_val, exe_mem_r_en);
    end
  endtask

  task automatic test_shifts();
    logic [31:0] rm_tab [5];
    logic [11:0] so_tab [5];
    logic [31:0] exp_tab[5];
    rm_tab = '{32'h0, 32'h8000_0000, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000};
    so_tab = '{12'h4FF, 12'hFC0, 12'h460, 12'h060, 12'h220};
    exp_tab = '{32'hFF00_0000, 32'hFFFF_FFFF, 32'h7812_3456, 32'h1234_5678, 32'h0800_0000};
    for (int i = 0; i < 5; i++) begin
      set_nop();
      exe_cmd = 4'b0001; val_rm = rm_tab[i]; shift_operand = so_tab[i];
      imm = (i == 0);
      step();
      total++;
      if (exe_alu_res !== exp_tab[i]) begin
        bad++;
        $display("FAIL shift_%0d: got %h want %h", i, exe_alu_res, exp_tab[i]);
      end
    end
  endtask

  task automatic test_freeze();
    set_nop();
    rst = 1'b1;
    step();
    set_imm_op(4'b0001, 1'b1, 32'd0, 12'h010);
    dest = 4'd2;
    step();
    set_imm_op(4'b0100, 1'b1, 32'd3, 12'h005);
    dest = 4'd7; freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (exe_alu_res !== 32'h10 || status !== 4'b0000 || exe_dest !== 4'd2) begin
        bad++;
        $display("FAIL freeze_hold_%0d: got res=%h nzcv=%b dest=%0d want 10/0000/2",
                 i, exe_alu_res, status, exe_dest);
      end
    end
    freeze = 1'b0;
    step();
    total++;
    if (exe_alu_res !== 32'hFFFF_FFFE || status !== 4'b1000 || exe_dest !== 4'd7) begin
      bad++;
      $display("FAIL freeze_release: got res=%h nzcv=%b dest=%0d want fffffffe/1000/7",
               exe_alu_res, status, exe_dest);
    end
    freeze = 1'b1;
    step();
    rst = 1'b1;
    step();
    total++;
    if (exe_alu_res !== 32'd0 || status !== 4'd0 || exe_dest !== 4'd0 || exe_wb_en !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_freeze: got res=%h nzcv=%b dest=%0d wb=%b want 0",
               exe_alu_res, status, exe_dest, exe_wb_en);
    end
    set_nop();
  endtask

  task automatic test_branch();
    logic [31:0] exp;
    set_nop();
    pc = 32'h100; signed_imm_24 = 24'hFFFFFE;
    #1;
    total++;
    if (br_addr !== 32'hF8) begin
      bad++; $display("FAIL br_neg: got %h want f8", br_addr);
    end
    freeze = 1'b1; pc = 32'h200; signed_imm_24 = 24'h000004;
    #1;
    total++;
    if (br_addr !== 32'h210) begin
      bad++; $display("FAIL br_frozen: got %h want 210", br_addr);
    end
    freeze = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pc = $urandom;
      signed_imm_24 = 24'($urandom);
      exp = 32'(longint'(pc) + 4 * longint'($signed(signed_imm_24)));
      #1;
      total++;
      if (br_addr !== exp) begin
        bad++; $display("FAIL br_rand_%0d: got %h want %h", i, br_addr, exp);
      end
    end
  endtask

  task automatic test_random();
    set_nop();
    for (int i = 0; i < 400; i++) begin
      exe_cmd = 4'($urandom_range(0, 15));
      wb_en = 1'($urandom); s_bit = 1'($urandom);
      imm = ($urandom_range(0, 3) == 0);
      mem_r_en = ($urandom_range(0, 5) == 0);
      mem_w_en = ($urandom_range(0, 5) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      val_rn = $urandom; val_rm = $urandom;
      if ($urandom_range(0, 3) == 0) val_rn = 32'h7FFF_FFFF + 32'($urandom_range(0, 2));
      mem_alu_res = $urandom; wb_value = $urandom;
      shift_operand = 12'($urandom); dest = 4'($urandom);
      sel_src1 = 2'($urandom); sel_src2 = 2'($urandom);
      step();
      total++;
      if (exe_alu_res !== m_res) begin
        bad++; $display("FAIL rand_res_%0d: got %h want %h", i, exe_alu_res, m_res);
      end
      total++;
      if (status !== m_status) begin
        bad++; $display("FAIL rand_nzcv_%0d: got %b want %b", i, status, m_status);
      end
      total++;
      if (exe_st_val !== m_st || exe_dest !== m_dest) begin
        bad++;
        $display("FAIL rand_st_%0d: got st=%h dest=%0d want %h/%0d",
                 i, exe_st_val, exe_dest, m_st, m_dest);
      end
      total++;
      if ({exe_wb_en, exe_mem_r_en, exe_mem_w_en} !== {m_wb, m_mr, m_mw}) begin
        bad++;
        $display("FAIL rand_ctrl_%0d: got %b want %b", i,
                 {exe_wb_en, exe_mem_r_en, exe_mem_w_en}, {m_wb, m_mr, m_mw});
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_sub_adc();
    test_overflow_mov();
    test_back_to_back();
    test_forwarding();
    test_shifts();
    test_freeze();
    test_branch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage ARM pipeline. It takes decoded operands from the ID/EX register and resolves data hazards using the `sel_src1`/`sel_src2` selects from the forwarding unit. It then computes the second operand (Val2), the ALU result and the branch target. Results are registered into the EXE/MEM pipeline register and the NZCV status register.

## Interface
- `WIDTH`, 32: datapath width. Only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `freeze`  in  1  holds the EXE/MEM register and the status register (memory wait).
- `exe_cmd`  in  4  ALU op: MOV 0001, MVN 1001, ADD/LDR/STR 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000.
- `wb_en`, `mem_r_en`, `mem_w_en`, `s_bit`, `imm`  in  1 each  control bits from ID/EX.
- `pc`  in  32  PC+4 of the instruction in EXE.
- `val_rn`, `val_rm`  in  32 each  register-file operands.
- `shift_operand`  in  12  instruction bits [11:0].
- `signed_imm_24`  in  24  branch offset.
- `dest`  in  4  destination register.
- `sel_src1`, `sel_src2`  in  2 each  forwarding selects: 00 register, 01 `mem_alu_res`, 10 `wb_value`, 11 treated as 00.
- `mem_alu_res`  in  32  forwarded value from the EXE/MEM stage.
- `wb_value`  in  32  forwarded value from the WB stage.
- `br_addr`  out  32  branch target (combinational).
- `status`  out  4  registered NZCV {N,Z,C,V}, fed to ID condition check.
- `exe_wb_en`, `exe_mem_r_en`, `exe_mem_w_en`  out  1 each  registered controls.
- `exe_alu_res`, `exe_st_val`  out  32 each  registered ALU result and store data.
- `exe_dest`  out  4  registered destination.

## Operation
- `op1` = mux(`sel_src1`; `val_rn`, `mem_alu_res`, `wb_value`). `op2_raw` = the same mux over `val_rm`.
- Val2 selection, in priority order:
  - `imm`=1: {24'b0, `shift_operand[7:0]`} rotated right by 2×`shift_operand[11:8]`.
  - else `mem_r_en`|`mem_w_en`: zero-extended `shift_operand[11:0]`.
  - else `op2_raw` shifted by `shift_operand[11:7]` (0–31), type `[6:5]`: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes the value unchanged.
- ALU, with `cin` = `status[1]`:
  - MOV = Val2; MVN = ~Val2.
  - ADD = op1+Val2; ADC adds `cin`.
  - SUB = op1−Val2; SBC subtracts ~`cin`.
  - AND, ORR, EOR are bitwise.
  - Unlisted codes give 0 and all flags unchanged.
- Flags:
  - N = res[31]; Z = (res==0).
  - Add ops: C = carry out of bit 31; V = operand signs equal and result sign differs.
  - Sub ops: C = NOT borrow; V = operand signs differ and result sign ≠ op1 sign.
  - MOV/MVN/logic: C and V keep their current values.
- LDR/STR use ADD, so the address is `op1`+Val2. `exe_st_val` = `op2_raw`, the forwarded Rm/Rd value, never Val2.
- `br_addr` = `pc` + (sign_ext(`signed_imm_24`) << 2), modulo 2^32.

## Timing
- Reset: on the rising edge with `rst`=1, `status`, `exe_alu_res`, `exe_st_val`, `exe_dest` and all `exe_*_en` outputs go to 0. `rst` wins over `freeze`.
- Latency: the EXE/MEM register captures on the clock edge ending the instruction's EXE cycle, so outputs are valid 1 cycle after the inputs.
- Status update: captured on the same edge, and only when `s_bit`=1, `freeze`=0 and `exe_cmd` is a listed code. Otherwise `status` holds.
- Back-to-back flag use: an ADC/SBC following an S-instruction in the very next cycle sees the updated C, because `status` is registered before that instruction reaches EXE. There is no combinational bypass of flags.
- `freeze`=1: every register holds its value; inputs are ignored. Combinational `br_addr` still tracks its inputs.
- Bubbles: the stage needs no valid bit. A bubble arrives as all-zero control bits and produces `exe_wb_en`/`exe_mem_*`=0.
- Forwarding muxes are purely combinational, with the same-cycle `mem_alu_res`/`wb_value`. Priority between MEM and WB is resolved upstream.

## Test plan
- Reset, then ADD with `val_rn`=5, `imm`=1, `shift_operand`=0x003 → after 1 edge `exe_alu_res`=8, `status` still 0000.
- SUB with S, op1=3, Val2=5 → `exe_alu_res`=0xFFFFFFFE, NZCV=1000. Next instruction ADC 0+0 → 0, because C=0.
- ADD with S, 0x7FFFFFFF+1 → 0x80000000, NZCV=1001. Then MOV with S of 0 → NZCV=0101 (C and V kept).
- `sel_src1`=01 with `mem_alu_res`=0x10, `sel_src2`=10 with `wb_value`=0x20, ADD register form, LSL 4 → result 0x210. STR variant: `exe_st_val`=0x20.
- Immediate 0xFF with rotate 4 → Val2=0xFF000000. ASR 31 of 0x80000000 → 0xFFFFFFFF. ROR 8 of 0x12345678 → 0x78123456.
- `freeze` held for 3 cycles during an S-instruction → outputs and `status` unchanged until `freeze` drops. `rst` asserted mid-freeze → all outputs 0. Branch: `pc`=0x100, offset 0xFFFFFE → `br_addr`=0xF8.
